dcache_port_arbiter: RTL
========================

# dcache_port_arbiter

Shares the single back-end data-cache port (`io_dcache_io_*`) between the load pipe and the store-commit path of `Back_End_With_Decode`. It grants one requester at a time round-robin and sequences the cache handshake: address phase, then data phase. It routes the response back to the winner and discards load responses killed by a pipeline flush (interrupt or redirect). At most one cache transaction is in flight.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `io_ld_req_valid`  in  1  load request
- `io_ld_req_ready`  out  1  load request accepted this cycle
- `io_ld_req_addr`  in  ADDR_W  load address
- `io_ld_req_size`  in  2  0=B, 1=H, 2=W, 3=D
- `io_ld_resp_valid`  out  1  one-cycle pulse, load data returned
- `io_ld_resp_data`  out  DATA_W  raw cache data (no extension)
- `io_st_req_valid`  in  1  committed store request
- `io_st_req_ready`  out  1  store accepted this cycle
- `io_st_req_addr`  in  ADDR_W  store address
- `io_st_req_data`  in  DATA_W  store data
- `io_st_req_size`  in  2  as load
- `io_st_resp_valid`  out  1  one-cycle pulse, store done
- `io_flush`  in  1  kill in-flight and same-cycle loads
- `io_busy`  out  1  state != IDLE
- `io_dcache_io_addr_valid`  out  1  address phase valid
- `io_dcache_io_addr_ready`  in  1  cache accepts address
- `io_dcache_io_addr`  out  ADDR_W  latched address
- `io_dcache_io_Mwout`  out  1  1=write, 0=read
- `io_dcache_io_MdataOut`  out  DATA_W  latched store data
- `io_dcache_io_Msize`  out  2  latched size
- `io_dcache_io_data_valid`  in  1  cache response valid
- `io_dcache_io_MdataIn`  in  DATA_W  read data

## Operation
- FSM states:
  - IDLE → ADDR on grant.
  - ADDR → IDLE when `addr_ready && data_valid` in the same cycle.
  - ADDR → RESP when `addr_ready` only.
  - RESP → IDLE when `data_valid`.
- Grant in IDLE only:
  - Winner is the sole valid requester.
  - If both are valid, the winner is the requester selected by `rr_ptr`; `rr_ptr` flips to the other requester after each grant.
  - `rr_ptr` resets to load.
- Grant is combinational: `ld_req_ready`/`st_req_ready` high in the IDLE cycle of the grant. At that edge, `owner`, addr, data, size and Mwout (store=1) are latched.
- Load is never granted in a cycle with `io_flush=1`. A store still may be granted in that cycle.
- ADDR: `addr_valid=1`, latched fields stable until `addr_ready`. Valid is never retracted.
- `killed` flag:
  - Set by `io_flush` while `owner`=load and state is ADDR or RESP.
  - Cleared on return to IDLE.
  - A killed load still completes the cache handshake, but its response is dropped: no `ld_resp_valid`.
- Stores are never killed by flush.
- On `data_valid` in the completing state:
  - Load (not killed): `ld_resp_data` ← MdataIn and `ld_resp_valid` pulses, both registered.
  - Store: `st_resp_valid` pulses, registered; MdataIn is ignored.
- `data_valid` in IDLE is spurious and is ignored.
- Flush in the same cycle as the response data: the load is killed and no pulse is issued.
- Reset (asynchronous, mid-transaction):
  - State → IDLE; killed, owner and `rr_ptr` cleared.
  - All outputs 0, including `addr_valid`, ready and resp pulses, `io_busy`, and latched addr/data/size.
  - The in-flight transaction is abandoned with no response.

## Timing
- Request accepted at edge N (ready high in cycle N-1 with valid).
- `addr_valid` high from cycle N until the `addr_ready` cycle.
- Zero-wait cache (addr_ready and data_valid in cycle N): resp pulse in cycle N+1. Next grant possible in cycle N+1.
- Throughput: one transaction per 2 cycles best case.
- Response pulses last exactly 1 cycle. `ld_resp_data` holds until the next load response.
- `io_busy` is registered state; ready outputs depend combinationally only on state, valids, `rr_ptr` and flush.

## Test plan
- Zero-wait path:
  - Stimulus: tie `addr_ready=data_valid=1` with MdataIn=0x4321; load addr 0x5, size 3.
  - Required: `ld_req_ready` in cycle 0, `addr_valid` with addr 0x5 and Mwout=0 in cycle 1, `ld_resp_valid` with data 0x4321 in cycle 2.
- Arbitration:
  - Stimulus: load and store (addr 0x9, data 0x5) valid continuously from reset.
  - Required: grants alternate load, store, load, store. The store's cycle shows Mwout=1 and MdataOut=0x5. `st_resp_valid` is one pulse per store.
- Stalled cache:
  - Stimulus: `addr_ready` low 3 cycles, then `data_valid` 200 ns later.
  - Required: addr, data and size stable throughout; no second grant; `io_busy`=1 until the response.
- Flush:
  - Stimulus: `io_flush` pulse in RESP for a load.
  - Required: no `ld_resp_valid`; state returns to IDLE on `data_valid`.
  - Stimulus: flush with `ld_req_valid` in IDLE.
  - Required: `ld_req_ready=0`; a pending store is granted instead.
- Reset mid-op:
  - Stimulus: assert `reset` asynchronously in ADDR.
  - Required: `addr_valid` drops immediately without waiting for a clock edge.
  - Stimulus: a later `data_valid` after reset.
  - Required: ignored; no resp pulse.

Source files
------------

// File: rtl/dcache_port_arbiter_if.sv
// dcache_port_arbiter_if: load/store requester and data-cache port signals
interface dcache_port_arbiter_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
  logic              io_ld_req_valid;
  logic              io_ld_req_ready;
  logic [ADDR_W-1:0] io_ld_req_addr;
  logic [1:0]        io_ld_req_size;
  logic              io_ld_resp_valid;
  logic [DATA_W-1:0] io_ld_resp_data;
  logic              io_st_req_valid;
  logic              io_st_req_ready;
  logic [ADDR_W-1:0] io_st_req_addr;
  logic [DATA_W-1:0] io_st_req_data;
  logic [1:0]        io_st_req_size;
  logic              io_st_resp_valid;
  logic              io_flush;
  logic              io_busy;
  logic              io_dcache_io_addr_valid;
  logic              io_dcache_io_addr_ready;
  logic [ADDR_W-1:0] io_dcache_io_addr;
  logic              io_dcache_io_Mwout;
  logic [DATA_W-1:0] io_dcache_io_MdataOut;
  logic [1:0]        io_dcache_io_Msize;
  logic              io_dcache_io_data_valid;
  logic [DATA_W-1:0] io_dcache_io_MdataIn;
  modport slave (
    input  io_ld_req_valid, io_ld_req_addr, io_ld_req_size,
    input  io_st_req_valid, io_st_req_addr, io_st_req_data, io_st_req_size, io_flush,
    input  io_dcache_io_addr_ready, io_dcache_io_data_valid, io_dcache_io_MdataIn,
    output io_ld_req_ready, io_ld_resp_valid, io_ld_resp_data,
    output io_st_req_ready, io_st_resp_valid, io_busy,
    output io_dcache_io_addr_valid, io_dcache_io_addr, io_dcache_io_Mwout,
    output io_dcache_io_MdataOut, io_dcache_io_Msize
  );
  modport master (
    output io_ld_req_valid, io_ld_req_addr, io_ld_req_size,
    output io_st_req_valid, io_st_req_addr, io_st_req_data, io_st_req_size, io_flush,
    output io_dcache_io_addr_ready, io_dcache_io_data_valid, io_dcache_io_MdataIn,
    input  io_ld_req_ready, io_ld_resp_valid, io_ld_resp_data,
    input  io_st_req_ready, io_st_resp_valid, io_busy,
    input  io_dcache_io_addr_valid, io_dcache_io_addr, io_dcache_io_Mwout,
    input  io_dcache_io_MdataOut, io_dcache_io_Msize
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: round-robin load/store sharing of one data-cache port, flush-aware
module dcache_port_arbiter #(parameter int ADDR_W = 64, parameter int DATA_W = 64) (
  input logic clock,
  input logic reset,
  dcache_port_arbiter_if.slave io
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t            state;
  logic              owner, killed, rr_ptr, busy, av, mw, ldrv, strv;
  logic              ld_ok, gnt_ld, gnt_st, done, ld_done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [1:0]        size;
  assign ld_ok   = io.io_ld_req_valid & ~io.io_flush;
  assign gnt_ld  = ~reset & (state == IDLE) & ld_ok & (~io.io_st_req_valid | ~rr_ptr);
  assign gnt_st  = ~reset & (state == IDLE) & io.io_st_req_valid & (~ld_ok | rr_ptr);
  assign done    = ((state == ADDR) & io.io_dcache_io_addr_ready & io.io_dcache_io_data_valid) |
                   ((state == RESP) & io.io_dcache_io_data_valid);
  assign ld_done = done & ~owner & ~killed & ~io.io_flush;
  assign io.io_ld_req_ready         = gnt_ld;
  assign io.io_st_req_ready         = gnt_st;
  assign io.io_busy                 = busy;
  assign io.io_ld_resp_valid        = ldrv;
  assign io.io_ld_resp_data         = rdata;
  assign io.io_st_resp_valid        = strv;
  assign io.io_dcache_io_addr_valid = av;
  assign io.io_dcache_io_addr       = addr;
  assign io.io_dcache_io_Mwout      = mw;
  assign io.io_dcache_io_MdataOut   = wdata;
  assign io.io_dcache_io_Msize      = size;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      killed <= 1'b0;
      rr_ptr <= 1'b0;
      busy   <= 1'b0;
      av     <= 1'b0;
      mw     <= 1'b0;
      ldrv   <= 1'b0;
      strv   <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      size   <= '0;
    end else begin
      ldrv <= ld_done;
      strv <= done & owner;
      if (ld_done) rdata <= io.io_dcache_io_MdataIn;
      // a killed load finishes its handshake; only its response is suppressed
      killed <= done ? 1'b0 : killed | (io.io_flush & ~owner & (state != IDLE));
      case (state)
        IDLE: if (gnt_ld | gnt_st) begin
          state  <= ADDR;
          busy   <= 1'b1;
          av     <= 1'b1;
          owner  <= gnt_st;
          mw     <= gnt_st;
          rr_ptr <= gnt_ld;
          addr   <= gnt_st ? io.io_st_req_addr : io.io_ld_req_addr;
          size   <= gnt_st ? io.io_st_req_size : io.io_ld_req_size;
          if (gnt_st) wdata <= io.io_st_req_data;
        end
        ADDR: if (io.io_dcache_io_addr_ready) begin
          av    <= 1'b0;
          state <= io.io_dcache_io_data_valid ? IDLE : RESP;
          busy  <= ~io.io_dcache_io_data_valid;
        end
        RESP: if (io.io_dcache_io_data_valid) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
